// File: rtl/csa_accumulator_if.sv
// ---------------------------------------------------------------------------
// csa_accumulator_if
// Bus bundle for csa_accumulator: operand input handshake, batch resolve
// request, busy flag and the result valid/ready handshake.
//   in_valid / in_ready / in_data    operand offer and acceptance
//   resolve_req                       single-cycle pulse closing the batch
//   busy                              high while resolving or holding result
//   out_valid / out_ready             result handshake
//   out_sum / out_ovf / out_count     batch total, overflow flag, operand count
// Modports: master drives operands/requests (producer side), slave is the
// accumulator itself.
// ---------------------------------------------------------------------------
interface csa_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             resolve_req;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [GUARD-1:0] out_count;

  modport master (
    output in_valid, in_data, resolve_req, out_ready,
    input  in_ready, busy, out_valid, out_sum, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, resolve_req, out_ready,
    output in_ready, busy, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
// Multi-operand accumulator holding its running total in carry-save form
// (sum vector + carry vector). Each accepted operand costs one 3:2
// compression; on resolve_req the redundant total is turned into binary by a
// slice-serial carry-propagate adder, SLICE bits per cycle, and then offered
// on a valid/ready output.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (discards any in-flight batch)
//   bus   csa_accumulator_if.slave (see interface file for signal list)
//
// Optional feature: define CSA_ACC_SAT_EN to saturate out_sum to all ones
// whenever the batch total overflows WIDTH bits (out_ovf still reports it).
// ---------------------------------------------------------------------------
module csa_accumulator #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8,
  parameter int SLICE = 8
) (
  input logic             clk,
  input logic             rst,
  csa_accumulator_if.slave bus
);

  localparam int N    = WIDTH + GUARD;
  localparam int NS   = N / SLICE;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [N-1:0]     s_vec;
  logic [N-1:0]     c_vec;
  logic [N-1:0]     res;
  logic [GUARD-1:0] cnt;
  logic [IDXW-1:0]  idx;
  logic             cy;

  logic             in_ready_int;
  logic             busy_int;
  logic             out_valid_int;
  logic             accept;
  logic             handshake;
  logic             last_slice;
  logic [N-1:0]     x_ext;
  // Only the low N-1 majority bits survive the left shift; the top one is the
  // dropped carry, which is always zero within the operand limit.
  logic [N-2:0]     maj;
  logic [SLICE:0]   slice_sum;

  logic [WIDTH-1:0] out_sum_int;
  logic             out_ovf_int;
  logic [GUARD-1:0] out_count_int;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake/status outputs
  always_comb begin
    next_state    = state;
    in_ready_int  = 1'b0;
    busy_int      = 1'b0;
    out_valid_int = 1'b0;
    case (state)
      ACCUM: begin
        // Counter saturating at all ones means the batch is full.
        in_ready_int = (cnt != {GUARD{1'b1}});
        if (bus.resolve_req) begin
          next_state = RESOLVE;
        end else begin
          next_state = ACCUM;
        end
      end
      RESOLVE: begin
        busy_int = 1'b1;
        if (last_slice) begin
          next_state = DONE;
        end else begin
          next_state = RESOLVE;
        end
      end
      DONE: begin
        busy_int      = 1'b1;
        out_valid_int = 1'b1;
        if (bus.out_ready) begin
          next_state = ACCUM;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = ACCUM;
      end
    endcase
  end

  // Datapath helpers: operand extension, 3:2 majority, current slice adder
  always_comb begin
    x_ext      = {{GUARD{1'b0}}, bus.in_data};
    maj        = (s_vec[N-2:0] & c_vec[N-2:0]) |
                 (s_vec[N-2:0] & x_ext[N-2:0]) |
                 (c_vec[N-2:0] & x_ext[N-2:0]);
    accept     = in_ready_int & bus.in_valid;
    handshake  = out_valid_int & bus.out_ready;
    last_slice = (idx == IDXW'(NS - 1));
    slice_sum  = {1'b0, s_vec[int'(idx) * SLICE +: SLICE]} +
                 {1'b0, c_vec[int'(idx) * SLICE +: SLICE]} +
                 {{SLICE{1'b0}}, cy};
  end

  // Carry-save total, operand count and slice-serial resolution
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vec <= '0;
      c_vec <= '0;
      res   <= '0;
      cnt   <= '0;
      idx   <= '0;
      cy    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // An operand accepted alongside resolve_req still joins the batch.
          if (accept) begin
            s_vec <= s_vec ^ c_vec ^ x_ext;
            c_vec <= {maj, 1'b0};
            cnt   <= cnt + GUARD'(1);
          end
          if (bus.resolve_req) begin
            idx <= '0;
            cy  <= 1'b0;
          end
        end
        RESOLVE: begin
          res[int'(idx) * SLICE +: SLICE] <= slice_sum[SLICE-1:0];
          cy                              <= slice_sum[SLICE];
          if (last_slice) begin
            idx <= '0;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (handshake) begin
            s_vec <= '0;
            c_vec <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  // Result presentation; all fields read zero outside DONE
  always_comb begin
    out_sum_int   = '0;
    out_ovf_int   = 1'b0;
    out_count_int = '0;
    if (state == DONE) begin
      out_ovf_int   = |res[N-1:WIDTH];
      out_count_int = cnt;
`ifdef CSA_ACC_SAT_EN
      if (out_ovf_int) begin
        out_sum_int = {WIDTH{1'b1}};
      end else begin
        out_sum_int = res[WIDTH-1:0];
      end
`else
      out_sum_int = res[WIDTH-1:0];
`endif
    end else begin
      out_sum_int = '0;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.busy      = busy_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_sum   = out_sum_int;
  assign bus.out_ovf   = out_ovf_int;
  assign bus.out_count = out_count_int;

endmodule
